// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential accumulator ALU.
// Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state).
package alu_seq_pkg;

    localparam int unsigned ALU_SEQ_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kAND = 4'd2,
        kXOR = 4'd3,
        kNOT = 4'd4,
        kLDA = 4'd5,
        kSHL = 4'd6,
        kSHR = 4'd7,
        kMUL = 4'd8,
        kCLR = 4'd9,
        kNOP = 4'd10
    } op_t;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one partial
// product per step. prod_*_o present the product as it will stand after
// the current step, so the caller can capture the result on the last step.
module alu_seq_mul #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         last_o,
    output logic [W-1:0] prod_hi_o,
    output logic [W-1:0] prod_lo_o
);

    localparam int unsigned   CW        = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [W-1:0]  mcand_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [CW-1:0] step_q;
    logic [W-1:0]  addend_s;
    logic [W:0]    sum_s;

    // Partial-product add; multiplier LSB selects the multiplicand.
    always_comb begin
        addend_s = lo_q[0] ? mcand_q : {W{1'b0}};
        sum_s    = {1'b0, hi_q} + {1'b0, addend_s};
    end

    assign prod_hi_o = sum_s[W:1];
    assign prod_lo_o = {sum_s[0], lo_q[W-1:1]};
    assign last_o    = (step_q == LAST_STEP);

    // Product/multiplier shift register and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= {W{1'b0}};
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
            step_q  <= {CW{1'b0}};
        end else if (load_i) begin
            mcand_q <= a_i;
            hi_q    <= {W{1'b0}};
            lo_q    <= b_i;
            step_q  <= {CW{1'b0}};
        end else if (step_i) begin
            hi_q    <= prod_hi_o;
            lo_q    <= prod_lo_o;
            step_q  <= step_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered-accumulator ALU with iterative shifts and a
// start/busy/done handshake. Optional macro ALU_SEQ_MUL_EN enables the
// shift-add multiply; without it MUL behaves as NOP and acc_hi stays 0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W        = ALU_SEQ_W_DEFAULT,
    parameter int unsigned SH_CNT_W = $clog2(W) + 1
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] in_a,
    input  logic         ci,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_hi,
    output logic         co,
    output logic         z,
    output logic         neg,
    output logic         busy,
    output logic         done
);

    localparam logic [SH_CNT_W-1:0] CNT_MAX  = SH_CNT_W'(W);
    localparam logic [SH_CNT_W-1:0] CNT_ONE  = SH_CNT_W'(1);
    localparam logic [SH_CNT_W-1:0] CNT_ZERO = {SH_CNT_W{1'b0}};

    state_t              state_q, state_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [W-1:0]        acc_hi_q, acc_hi_d;
    logic                co_q, co_d;
    logic                z_q, z_d;
    logic                neg_q, neg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic                sh_left_q, sh_left_d;
    logic                sh_ci_q, sh_ci_d;

    op_t                 op_s;
    logic [W:0]          add_s;
    logic [W:0]          sub_s;
    logic [SH_CNT_W-1:0] cnt_raw_s;
    logic [SH_CNT_W-1:0] cnt_s;
    logic                fin_s;
    logic                shift_step_s;
    logic                mul_fin_s;
    logic                flag_upd_s;

    assign op_s      = op_t'(op);
    assign add_s     = {1'b0, acc_q} + {1'b0, in_a} + {{W{1'b0}}, ci};
    assign sub_s     = {1'b0, acc_q} + {1'b0, ~in_a} + {{W{1'b0}}, 1'b1};
    assign cnt_raw_s = in_a[SH_CNT_W-1:0];
    assign cnt_s     = (cnt_raw_s > CNT_MAX) ? CNT_MAX : cnt_raw_s;

`ifdef ALU_SEQ_MUL_EN
    logic         mul_load_s;
    logic         mul_step_s;
    logic         mul_last_s;
    logic [W-1:0] mul_hi_s;
    logic [W-1:0] mul_lo_s;

    alu_seq_mul #(.W(W)) u_mul (
        .clk       (CLK),
        .rst_n     (reset_n),
        .load_i    (mul_load_s),
        .step_i    (mul_step_s),
        .a_i       (acc_q),
        .b_i       (in_a),
        .last_o    (mul_last_s),
        .prod_hi_o (mul_hi_s),
        .prod_lo_o (mul_lo_s)
    );
`endif

    // Next-state and datapath decode for the IDLE/SHIFT/MUL controller.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_hi_d     = acc_hi_q;
        co_d         = co_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sh_cnt_d     = sh_cnt_q;
        sh_left_d    = sh_left_q;
        sh_ci_d      = sh_ci_q;
        fin_s        = 1'b0;
        shift_step_s = 1'b0;
        mul_fin_s    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_load_s   = 1'b0;
        mul_step_s   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_s)
                        kADD: begin
                            acc_d = add_s[W-1:0];
                            co_d  = add_s[W];
                            fin_s = 1'b1;
                        end
                        kSUB: begin
                            acc_d = sub_s[W-1:0];
                            co_d  = sub_s[W];
                            fin_s = 1'b1;
                        end
                        kAND: begin
                            acc_d = acc_q & in_a;
                            fin_s = 1'b1;
                        end
                        kXOR: begin
                            acc_d = acc_q ^ in_a;
                            fin_s = 1'b1;
                        end
                        kNOT: begin
                            acc_d = ~acc_q;
                            fin_s = 1'b1;
                        end
                        kLDA: begin
                            acc_d = in_a;
                            fin_s = 1'b1;
                        end
                        kSHL, kSHR: begin
                            if (cnt_s == CNT_ZERO) begin
                                fin_s = 1'b1;
                            end else begin
                                state_d   = SHIFT;
                                busy_d    = 1'b1;
                                sh_cnt_d  = cnt_s;
                                sh_left_d = (op_s == kSHL);
                                sh_ci_d   = ci;
                            end
                        end
                        kMUL: begin
`ifdef ALU_SEQ_MUL_EN
                            mul_load_s = 1'b1;
                            state_d    = MUL;
                            busy_d     = 1'b1;
`else
                            fin_s      = 1'b1;
`endif
                        end
                        kCLR: begin
                            acc_d = {W{1'b0}};
                            co_d  = 1'b0;
                            fin_s = 1'b1;
                        end
                        default: begin
                            fin_s = 1'b1;
                        end
                    endcase
                end else begin
                    fin_s = 1'b0;
                end
            end
            SHIFT: begin
                shift_step_s = 1'b1;
                sh_cnt_d     = sh_cnt_q - CNT_ONE;
                if (sh_left_q) begin
                    acc_d = {acc_q[W-2:0], sh_ci_q};
                    co_d  = acc_q[W-1];
                end else begin
                    acc_d = {1'b0, acc_q[W-1:1]};
                    co_d  = acc_q[0];
                end
                fin_s = (sh_cnt_q == CNT_ONE);
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                mul_step_s = 1'b1;
                if (mul_last_s) begin
                    acc_d     = mul_lo_s;
                    acc_hi_d  = mul_hi_s;
                    co_d      = (mul_hi_s != {W{1'b0}});
                    mul_fin_s = 1'b1;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    mul_fin_s = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Any non-MUL completion clears acc_hi and returns to IDLE.
        if (fin_s) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            acc_hi_d = {W{1'b0}};
        end else begin
            sh_ci_d  = sh_ci_d;
        end

        flag_upd_s = fin_s | shift_step_s | mul_fin_s;
        if (flag_upd_s) begin
            z_d   = (acc_d == {W{1'b0}});
            neg_d = acc_d[W-1];
        end else begin
            z_d   = z_q;
            neg_d = neg_q;
        end
    end

    // State and output registers; reset abandons any op in flight.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= {W{1'b0}};
            acc_hi_q  <= {W{1'b0}};
            co_q      <= 1'b0;
            z_q       <= 1'b0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sh_cnt_q  <= CNT_ZERO;
            sh_left_q <= 1'b0;
            sh_ci_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_hi_q  <= acc_hi_d;
            co_q      <= co_d;
            z_q       <= z_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_left_q <= sh_left_d;
            sh_ci_q   <= sh_ci_d;
        end
    end

    assign acc    = acc_q;
    assign acc_hi = acc_hi_q;
    assign co     = co_q;
    assign z      = z_q;
    assign neg    = neg_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven self-checking bench for alu_seq (W=8) with a
// scoreboard queue, plus hand sequences for busy/back-to-back/reset cases.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic       ci;
        logic [7:0] exp_acc;
        logic [7:0] exp_hi;
        logic       exp_co;
        logic       exp_z;
        logic       exp_neg;
        int         exp_busy;
    } vec_t;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] in_a;
    logic       ci;
    logic [7:0] acc;
    logic [7:0] acc_hi;
    logic       co;
    logic       z;
    logic       neg;
    logic       busy;
    logic       done;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t sb[$];
    vec_t tbl[$];

    alu_seq #(.W(8)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .in_a    (in_a),
        .ci      (ci),
        .acc     (acc),
        .acc_hi  (acc_hi),
        .co      (co),
        .z       (z),
        .neg     (neg),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] a, input logic c,
                                input logic [7:0] e_acc, input logic [7:0] e_hi,
                                input logic e_co, input logic e_z, input logic e_neg,
                                input int e_busy);
        vec_t v;
        v.op = o; v.a = a; v.ci = c;
        v.exp_acc = e_acc; v.exp_hi = e_hi; v.exp_co = e_co;
        v.exp_z = e_z; v.exp_neg = e_neg; v.exp_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op, push its expectation, wait (bounded) for done, compare.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   n_busy;
        bit   got;
        @(negedge CLK);
        op = v.op; in_a = v.a; ci = v.ci; start = 1'b1;
        sb.push_back(v);
        @(negedge CLK);
        start = 1'b0;
        n_busy = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) n_busy++;
                @(negedge CLK);
            end
        end
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout: done not seen within 40 cycles", tag);
        end else begin
            check({tag, " acc"},    32'(acc),    32'(e.exp_acc));
            check({tag, " acc_hi"}, 32'(acc_hi), 32'(e.exp_hi));
            check({tag, " co"},     32'(co),     32'(e.exp_co));
            check({tag, " z"},      32'(z),      32'(e.exp_z));
            check({tag, " neg"},    32'(neg),    32'(e.exp_neg));
            check({tag, " busy_cycles"}, 32'(n_busy), 32'(e.exp_busy));
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 4'd0; in_a = 8'h00; ci = 1'b0;

        // Vector table: each row starts from the state left by the previous one.
        tbl.push_back(mk(kLDA, 8'hF0, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kADD, 8'h20, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(kLDA, 8'h05, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(kSUB, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0));
        tbl.push_back(mk(kSUB, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kAND, 8'h0F, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(kXOR, 8'hFF, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kNOT, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(kCLR, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0));
        tbl.push_back(mk(kLDA, 8'h81, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kSHL, 8'h03, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 3));
        tbl.push_back(mk(kLDA, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kADD, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0));
        tbl.push_back(mk(kSHR, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0));
        tbl.push_back(mk(kLDA, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kSHR, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8));
        tbl.push_back(mk(4'hF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0));
        tbl.push_back(mk(kLDA, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0));
`ifdef ALU_SEQ_MUL_EN
        tbl.push_back(mk(kMUL, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 8));
        tbl.push_back(mk(kNOP, 8'h00, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(kSHL, 8'h02, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(kSHR, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1));
`else
        tbl.push_back(mk(kMUL, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kNOP, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0));
        tbl.push_back(mk(kSHL, 8'h02, 1'b0, 8'hFC, 8'h00, 1'b1, 1'b0, 1'b1, 2));
        tbl.push_back(mk(kSHR, 8'h01, 1'b0, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b0, 1));
`endif

        // Reset state.
        repeat (3) @(negedge CLK);
        check("reset acc",  32'(acc),    32'h0);
        check("reset hi",   32'(acc_hi), 32'h0);
        check("reset co",   32'(co),     32'h0);
        check("reset z",    32'(z),      32'h0);
        check("reset neg",  32'(neg),    32'h0);
        check("reset busy", 32'(busy),   32'h0);
        check("reset done", 32'(done),   32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // start while busy is ignored; start alongside done is accepted.
        run_vec(mk(kLDA, 8'h81, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 0), "pre_busy");
        @(negedge CLK);
        op = kSHL; in_a = 8'h03; ci = 1'b1; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("busy step%0d", k), 32'(busy), 32'h1);
            check($sformatf("nodone step%0d", k), 32'(done), 32'h0);
            op = kLDA; in_a = 8'h55; ci = 1'b0; start = 1'b1;
        end
        @(negedge CLK);
        check("shl3 done", 32'(done), 32'h1);
        check("shl3 acc",  32'(acc),  32'h0F);
        check("shl3 co",   32'(co),   32'h0);
        check("shl3 busy", 32'(busy), 32'h0);
        op = kLDA; in_a = 8'h33; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("b2b acc",  32'(acc),  32'h33);
        check("b2b done", 32'(done), 32'h1);
        @(negedge CLK);
        check("done pulse width", 32'(done), 32'h0);

        // Reset in the middle of a 5-step shift.
        run_vec(mk(kLDA, 8'h01, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0), "pre_rst");
        @(negedge CLK);
        op = kSHL; in_a = 8'h05; ci = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("mid-shift acc", 32'(acc),  32'h04);
        check("mid-shift busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst acc",  32'(acc),  32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst co",   32'(co),   32'h0);
        check("rst z",    32'(z),    32'h0);
        check("rst neg",  32'(neg),  32'h0);
        check("rst hi",   32'(acc_hi), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("rst hold done%0d", k), 32'(done), 32'h0);
        end
        reset_n = 1'b1;
        run_vec(mk(kADD, 8'h22, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 0), "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
